riscv_fetch_unit: RTL and testbench
===================================

# riscv_fetch_unit

Instruction fetch front-end sitting directly upstream of the RV32 core's decode/execute stage. Generates sequential PCs, issues requests to a variable-latency instruction memory over a valid/ready request channel, buffers in-order responses in a small queue, and presents (pc, instr) pairs to the core through a valid/ready handshake. Branch/jump redirects from the core flush the queue and discard responses still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- QUEUE_DEPTH, 4: instruction queue entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  XLEN  word-aligned fetch address.
- imem_rsp_valid_i  in  1  response valid; responses return in request order, always accepted.
- imem_rsp_data_i  in  32  instruction word.
- redirect_i  in  1  core requests PC change (taken branch/JAL/JALR).
- redirect_pc_i  in  XLEN  redirect target.
- instr_valid_o  out  1  queue head valid.
- instr_ready_i  in  1  core consumes head.
- instr_o  out  32  head instruction.
- pc_o  out  XLEN  head PC.
- misalign_o  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- fetch_pc register: reset RESET_PC; +4 on each request handshake (valid & ready); loads redirect_pc_i on redirect.
- Credits: credit = QUEUE_DEPTH − count − outstanding. imem_req_valid_o = (credit > 0) & ~halted. Request may be withdrawn (valid need not hold).
- outstanding counter: +1 on request handshake, −1 on response; simultaneous → unchanged. Width clog2(QUEUE_DEPTH)+1.
- Response with drop_cnt == 0: push {pc, instr} into queue; pc comes from a parallel in-order PC tag queue written at request time.
- Redirect (cycle N): queue and PC tags flushed; drop_cnt ← outstanding after cycle-N updates (includes a request handshaking in cycle N; a response arriving in cycle N is discarded). Each later response while drop_cnt > 0 decrements drop_cnt and is discarded.
- Pop on instr_valid_o & instr_ready_i. Redirect in same cycle as pop: flush wins, pop irrelevant.
- Queue full: credit prevents overflow; push when full is an assertion failure.

## Timing
- Reset values: imem_req_valid_o 0 during reset, imem_req_addr_o RESET_PC, instr_valid_o 0, instr_o 0, pc_o 0, misalign_o 0; all counters 0.
- First request asserted in first cycle after reset release.
- Response at cycle N → instr_valid_o at N+1 (registered, no bypass). Minimum request-to-issue latency 2 cycles with 1-cycle memory.
- Credit freed by pop is usable the following cycle; sustained 1 instr/cycle requires QUEUE_DEPTH ≥ 3 and 1-cycle memory.
- Redirect at N: instr_valid_o 0 at N+1; request to redirect_pc_i may issue at N+1 if credit > 0.
- Reset mid-operation: all state cleared immediately; in-flight memory responses after release are the environment's responsibility (memory must also be reset).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc_i[1:0] ≠ 0 sets misalign_o and halted; no requests issue; queue stays empty; next aligned redirect clears both and resumes.
- Undefined: redirect_pc_i[1:0] ignored (forced 0); misalign_o tied 0; no halted state.

## Structure
- riscv_pkg: XLEN, fetch_entry_t {pc, instr}, default RESET_PC constant.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full/empty; instantiated for the instruction queue (PC tag queue may reuse it with XLEN width).

## Test plan
- Reset release, 1-cycle memory always ready, instr_ready_i=1 → pc_o 0,4,8,… one per cycle from cycle 2, instr_o matches memory.
- instr_ready_i=0 for 10 cycles → exactly QUEUE_DEPTH requests issued (0x0–0xC), then imem_req_valid_o 0; release → in-order drain, fetch resumes at 0x10.
- 3-cycle memory latency, 3 outstanding, redirect to 0x100 → the 3 stale responses dropped, next pc_o 0x100.
- Redirect coincident with response and request handshake → both stale; first issued pc_o is redirect target.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 → misalign_o 1, no requests; redirect to 0x200 → misalign_o 0, pc_o 0x200.
- Assert rst_i mid-stream with queue full → next cycle all outputs at reset values; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 fetch front-end.
// Holds the XLEN width, the queue entry layout and the default reset PC.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

   // Clears the two low address bits so fetches stay word-aligned.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with push, pop, flush and occupancy count.
// Used for both the instruction queue and the in-order PC tag queue.
module fetch_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Flush overrides both push and pop; a full queue never takes new data.
   assign do_push = push & ~flush & ~full;
   assign do_pop  = pop & ~flush & ~empty;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && full && !flush));

endmodule

// File: rtl/riscv_fetch_unit.sv
// RV32 instruction fetch front-end: credit-based requests, in-order response queue, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target until an aligned one.
module riscv_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int              QUEUE_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [31:0]     imem_rsp_data_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            misalign_o
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_nxt;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   instr_count;
   logic [CW-1:0]   tag_count;
   logic [CW:0]     used;
   logic            has_credit;
   logic            halted;
   logic            req_hs;
   logic            rsp_accept;
   logic            rsp_drop;
   logic            instr_pop;
   logic            instr_full;
   logic            instr_empty;
   logic            tag_full;
   logic            tag_empty;
   logic [XLEN-1:0] tag_head;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic target_misaligned;

   assign target_pc         = redirect_pc_i;
   assign target_misaligned = |redirect_pc_i[1:0];

   // Sticky until the core redirects to an aligned target.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)           halted <= 1'b0;
      else if (redirect_i) halted <= target_misaligned;
   end
`else
   assign target_pc = align_pc(redirect_pc_i);
   assign halted    = 1'b0;
`endif

   assign misalign_o = halted;

   // Entries already queued plus those still in flight bound what may be requested.
   assign used       = {1'b0, instr_count} + {1'b0, outstanding};
   assign has_credit = (used < DEPTH_C);

   assign imem_req_valid_o = has_credit & ~halted & ~rst_i;
   assign imem_req_addr_o  = fetch_pc;
   assign req_hs           = imem_req_valid_o & imem_req_ready_i;

   // A response in the redirect cycle is stale, as is any counted by drop_cnt.
   assign rsp_drop   = imem_rsp_valid_i & (redirect_i | (drop_cnt != '0));
   assign rsp_accept = imem_rsp_valid_i & ~redirect_i & (drop_cnt == '0);

   assign instr_pop = instr_valid_o & instr_ready_i;

   always_comb begin
      outstanding_nxt = outstanding;
      unique case ({req_hs, imem_rsp_valid_i})
         2'b10:   outstanding_nxt = outstanding + 1'b1;
         2'b01:   outstanding_nxt = outstanding - 1'b1;
         default: outstanding_nxt = outstanding;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_i)  fetch_pc <= target_pc;
         else if (req_hs) fetch_pc <= fetch_pc + XLEN'(4);
         // Everything still in flight after this cycle belongs to the old path.
         if (redirect_i)    drop_cnt <= outstanding_nxt;
         else if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
   end

   fetch_queue #(
      .WIDTH (XLEN),
      .DEPTH (QUEUE_DEPTH)
   ) u_tag_queue (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (req_hs & ~redirect_i),
      .push_data (fetch_pc),
      .pop       (rsp_accept),
      .flush     (redirect_i),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   assign push_entry = {tag_head, imem_rsp_data_i};

   fetch_queue #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (QUEUE_DEPTH)
   ) u_instr_queue (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (rsp_accept),
      .push_data (push_entry),
      .pop       (instr_pop),
      .flush     (redirect_i),
      .head      (head_entry),
      .count     (instr_count),
      .full      (instr_full),
      .empty     (instr_empty)
   );

   // Outputs read as zero whenever the queue holds nothing.
   assign instr_valid_o = ~instr_empty;
   assign instr_o       = instr_empty ? 32'h0 : head_entry.instr;
   assign pc_o          = instr_empty ? '0 : head_entry.pc;

   a_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      !(imem_rsp_valid_i && (outstanding == '0)));
   a_tag_present: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_accept && tag_empty));
   a_tag_room: assert property (@(posedge clk_i) disable iff (rst_i)
      !(req_hs && !redirect_i && tag_full));
   a_tags_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
      tag_count <= outstanding);
   a_instr_room: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_accept && instr_full));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with an in-order variable-latency memory model.
// Covers streaming, backpressure, redirects, misaligned redirect (FETCH_MISALIGN_CHECK_EN) and mid-run reset.
module tb_riscv_fetch_unit;
   import riscv_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b1;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = 32'h0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        misalign_o;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int mem_lat = 1;
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   riscv_fetch_unit #(
      .RESET_PC    (32'h0000_0000),
      .QUEUE_DEPTH (4)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .pc_o             (pc_o),
      .misalign_o       (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Memory: record handshakes at the edge, return them in order after mem_lat cycles.
   always @(posedge clk_i) begin
      cyc = cyc + 1;
      if (rst_i) begin
         pend_addr.delete();
         pend_due.delete();
      end else begin
         if (imem_rsp_valid_i && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         if (imem_req_valid_o && imem_req_ready_i) begin
            pend_addr.push_back(imem_req_addr_o);
            pend_due.push_back(cyc + mem_lat - 1);
         end
      end
   end

   always @(negedge clk_i) begin
      if (!rst_i && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = mem_word(pend_addr[0]);
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = 32'h0;
      end
   end

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      redirect_i = 1'b0;
      instr_ready_i = 1'b0;
      imem_req_ready_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      n_cmp++; if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid_o); end
      n_cmp++; if (imem_req_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr_o); end
      n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid_o); end
      n_cmp++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", instr_o); end
      n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc_o); end
      n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
      rst_i = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid_o); end
      n_cmp++; if (imem_req_addr_o !== 32'h0) begin n_fail++; $display("FAIL first_req_addr: got %h want 00000000", imem_req_addr_o); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      mem_lat = 1;
      do_reset();
      instr_ready_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) tick();
         exp_pc = 32'(4 * (c - 2));
         n_cmp++; if (instr_valid_o !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, instr_valid_o, (c >= 2)); end
         if (c >= 2) begin
            n_cmp++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL stream_pc c%0d: got %h want %h", c, pc_o, exp_pc); end
            n_cmp++; if (instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stream_instr c%0d: got %h want %h", c, instr_o, mem_word(exp_pc)); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      int hs_cnt;
      logic seen_req;
      mem_lat = 1;
      do_reset();
      exp_addr = 32'h0;
      hs_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         if (imem_req_valid_o && imem_req_ready_i) begin
            n_cmp++; if (imem_req_addr_o !== exp_addr) begin n_fail++; $display("FAIL bp_req_addr: got %h want %h", imem_req_addr_o, exp_addr); end
            exp_addr = exp_addr + 32'd4;
            hs_cnt++;
         end
      end
      n_cmp++; if (hs_cnt != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", hs_cnt); end
      n_cmp++; if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled: got %b want 0", imem_req_valid_o); end
      n_cmp++; if (pc_o !== 32'h0 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_head: got %h/%b want 00000000/1", pc_o, instr_valid_o); end
      instr_ready_i = 1'b1;
      exp_pc = 32'h0;
      seen_req = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) tick();
         if (instr_valid_o) begin
            n_cmp++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL bp_drain_pc: got %h want %h", pc_o, exp_pc); end
            n_cmp++; if (instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL bp_drain_instr: got %h want %h", instr_o, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
         end
         if (imem_req_valid_o && !seen_req) begin
            seen_req = 1'b1;
            n_cmp++; if (imem_req_addr_o !== 32'h10) begin n_fail++; $display("FAIL bp_resume_addr: got %h want 00000010", imem_req_addr_o); end
         end
      end
      n_cmp++; if (seen_req !== 1'b1) begin n_fail++; $display("FAIL bp_resume_seen: got %b want 1", seen_req); end
      n_cmp++; if (exp_pc !== 32'h40) begin n_fail++; $display("FAIL bp_drain_total: got next pc %h want 00000040", exp_pc); end
   endtask

   task automatic test_redirect_latency();
      logic [31:0] exp_pc;
      int n_seen;
      mem_lat = 4;
      do_reset();
      instr_ready_i = 1'b1;
      exp_pc = 32'h100;
      n_seen = 0;
      for (int c = 0; c < 25; c++) begin
         if (c > 0) tick();
         if (c == 3) begin
            imem_req_ready_i = 1'b0;
            redirect_i = 1'b1;
            redirect_pc_i = 32'h100;
         end
         if (c == 4) begin
            redirect_i = 1'b0;
            imem_req_ready_i = 1'b1;
            n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_flush_valid: got %b want 0", instr_valid_o); end
            n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h100) begin n_fail++; $display("FAIL lat_target_req: got %b/%h want 1/00000100", imem_req_valid_o, imem_req_addr_o); end
         end
         if (c >= 4 && instr_valid_o) begin
            n_cmp++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL lat_pc: got %h want %h", pc_o, exp_pc); end
            n_cmp++; if (instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL lat_instr: got %h want %h", instr_o, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            n_seen++;
         end
      end
      n_cmp++; if (n_seen < 4) begin n_fail++; $display("FAIL lat_progress: got %0d want >=4", n_seen); end
      mem_lat = 1;
   endtask

   task automatic test_redirect_coincident();
      logic [31:0] exp_pc;
      int n_seen;
      mem_lat = 1;
      do_reset();
      instr_ready_i = 1'b1;
      exp_pc = 32'h300;
      n_seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) tick();
         if (c == 5) begin
            n_cmp++; if (imem_req_valid_o !== 1'b1 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL coin_busy: got %b/%b want 1/1", imem_req_valid_o, instr_valid_o); end
            redirect_i = 1'b1;
            redirect_pc_i = 32'h300;
         end
         if (c == 6) begin
            redirect_i = 1'b0;
            n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL coin_flush_valid: got %b want 0", instr_valid_o); end
            n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h300) begin n_fail++; $display("FAIL coin_target_req: got %b/%h want 1/00000300", imem_req_valid_o, imem_req_addr_o); end
         end
         if (c >= 6 && instr_valid_o) begin
            n_cmp++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL coin_pc: got %h want %h", pc_o, exp_pc); end
            n_cmp++; if (instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL coin_instr: got %h want %h", instr_o, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            n_seen++;
         end
      end
      n_cmp++; if (n_seen != 12) begin n_fail++; $display("FAIL coin_progress: got %0d want 12", n_seen); end
   endtask

   task automatic test_misalign();
      logic [31:0] exp_pc;
      int n_seen;
      mem_lat = 1;
      do_reset();
      instr_ready_i = 1'b1;
      n_seen = 0;
      for (int c = 0; c < 5; c++) tick();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h102;
      tick();
      redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         n_cmp++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_flag_set: got %b want 1", misalign_o); end
         n_cmp++; if (imem_req_valid_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_halted: got req %b instr %b want 0/0", imem_req_valid_o, instr_valid_o); end
      end
      redirect_i = 1'b1;
      redirect_pc_i = 32'h200;
      tick();
      redirect_i = 1'b0;
      n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_flag_clear: got %b want 0", misalign_o); end
      exp_pc = 32'h200;
`else
      n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_flag_off: got %b want 0", misalign_o); end
      exp_pc = 32'h100;
`endif
      n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== exp_pc) begin n_fail++; $display("FAIL mis_resume_req: got %b/%h want 1/%h", imem_req_valid_o, imem_req_addr_o, exp_pc); end
      for (int c = 0; c < 8; c++) begin
         if (c > 0) tick();
         if (instr_valid_o) begin
            n_cmp++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL mis_pc: got %h want %h", pc_o, exp_pc); end
            n_cmp++; if (instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL mis_instr: got %h want %h", instr_o, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            n_seen++;
         end
      end
      n_cmp++; if (n_seen != 6) begin n_fail++; $display("FAIL mis_progress: got %0d want 6", n_seen); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_pc;
      int n_seen;
      mem_lat = 1;
      do_reset();
      for (int c = 0; c < 10; c++) tick();
      n_cmp++; if (instr_valid_o !== 1'b1 || imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_full: got valid %b req %b want 1/0", instr_valid_o, imem_req_valid_o); end
      rst_i = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid: got %b want 0", imem_req_valid_o); end
      n_cmp++; if (imem_req_addr_o !== 32'h0) begin n_fail++; $display("FAIL mid_req_addr: got %h want 00000000", imem_req_addr_o); end
      n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_instr_valid: got %b want 0", instr_valid_o); end
      n_cmp++; if (instr_o !== 32'h0 || pc_o !== 32'h0) begin n_fail++; $display("FAIL mid_head: got %h/%h want 0/0", instr_o, pc_o); end
      n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mid_misalign: got %b want 0", misalign_o); end
      tick();
      rst_i = 1'b0;
      #1;
      instr_ready_i = 1'b1;
      exp_pc = 32'h0;
      n_seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) tick();
         if (instr_valid_o) begin
            n_cmp++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL mid_restart_pc: got %h want %h", pc_o, exp_pc); end
            n_cmp++; if (instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL mid_restart_instr: got %h want %h", instr_o, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            n_seen++;
         end
      end
      n_cmp++; if (n_seen != 10) begin n_fail++; $display("FAIL mid_restart_count: got %0d want 10", n_seen); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_latency();
      test_redirect_coincident();
      test_misalign();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
